// File: rtl/pong_game_ctrl.sv
// Pong game-flow controller: newgame/play/newball/over sequencing, BCD score,
// balls remaining, and a shared down-counter for the relaunch pause and game-over hold.
module pong_game_ctrl #(
   parameter int BALLS        = 3,
   parameter int TIMER_CYCLES = 50_000_000,
   parameter int TIMER_W      = 26
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] btn1,
   input  logic [1:0] btn2,
   input  logic       hit,
   input  logic       miss,
   output logic       gra_still,
   output logic [1:0] game_state,
   output logic [3:0] score_d1,
   output logic [3:0] score_d0,
   output logic [1:0] balls_left
);

   typedef enum logic [1:0] {
      NEWGAME = 2'b00,
      PLAY    = 2'b01,
      OVER    = 2'b10,
      NEWBALL = 2'b11
   } state_t;

   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(TIMER_CYCLES - 1);
   localparam logic [1:0]         BALLS_INIT = 2'(BALLS);
   localparam logic [1:0]         BALLS_M1   = 2'(BALLS - 1);

   state_t               state_reg, state_next;
   logic [3:0]           d1_reg, d1_next, d0_reg, d0_next;
   logic [1:0]           balls_reg, balls_next;
   logic [TIMER_W-1:0]   timer_reg, timer_next;
   logic                 btn_any_q;
   logic                 btn_any, start, timer_up;
   logic                 load_timer, score_inc, score_clr;

   assign btn_any  = (|btn1) | (|btn2);
   assign start    = btn_any & ~btn_any_q;
   assign timer_up = (timer_reg == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= NEWGAME;
         d1_reg    <= 4'd0;
         d0_reg    <= 4'd0;
         balls_reg <= BALLS_INIT;
         timer_reg <= '0;
         btn_any_q <= 1'b0;
      end else begin
         state_reg <= state_next;
         d1_reg    <= d1_next;
         d0_reg    <= d0_next;
         balls_reg <= balls_next;
         timer_reg <= timer_next;
         btn_any_q <= btn_any;
      end
   end

   always_comb begin
      state_next = state_reg;
      balls_next = balls_reg;
      load_timer = 1'b0;
      score_inc  = 1'b0;
      score_clr  = 1'b0;
      case (state_reg)
         NEWGAME: begin
            if (start) begin
               state_next = PLAY;
               balls_next = BALLS_M1;
               score_clr  = 1'b1;
            end
         end
         PLAY: begin
            // a hit in the same cycle as the miss still scores
            score_inc = hit;
            if (miss) begin
               load_timer = 1'b1;
               if (balls_reg == 2'd0) begin
                  state_next = OVER;
               end else begin
                  state_next = NEWBALL;
                  balls_next = balls_reg - 2'd1;
               end
            end
         end
         NEWBALL: begin
            if (start && timer_up) state_next = PLAY;
         end
         OVER: begin
            if (timer_up) begin
               state_next = NEWGAME;
               balls_next = BALLS_INIT;
               score_clr  = 1'b1;
            end
         end
         default: state_next = NEWGAME;
      endcase
   end

   // BCD increment saturating at 99
   always_comb begin
      d1_next = d1_reg;
      d0_next = d0_reg;
      if (score_clr) begin
         d1_next = 4'd0;
         d0_next = 4'd0;
      end else if (score_inc && !(d1_reg == 4'd9 && d0_reg == 4'd9)) begin
         if (d0_reg == 4'd9) begin
            d0_next = 4'd0;
            d1_next = d1_reg + 4'd1;
         end else begin
            d0_next = d0_reg + 4'd1;
         end
      end
   end

   always_comb begin
      timer_next = timer_reg;
      if (load_timer)     timer_next = TIMER_LOAD;
      else if (!timer_up) timer_next = timer_reg - 1'b1;
   end

   assign game_state = state_reg;
   assign gra_still  = (state_reg != PLAY);
   assign score_d1   = d1_reg;
   assign score_d0   = d0_reg;
   assign balls_left = balls_reg;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Scoreboard bench for pong_game_ctrl: stimulus queues expected outputs per cycle,
// a monitor after each rising edge pops and compares them.
module tb_pong_game_ctrl;

   localparam logic [1:0] ST_NG = 2'b00, ST_PLAY = 2'b01, ST_OVER = 2'b10, ST_NB = 2'b11;

   logic       clk = 1'b0;
   logic       reset;
   logic [1:0] btn1, btn2;
   logic       hit, miss;
   logic       gra_still;
   logic [1:0] game_state;
   logic [3:0] score_d1, score_d0;
   logic [1:0] balls_left;

   pong_game_ctrl #(.BALLS(3), .TIMER_CYCLES(16), .TIMER_W(5)) dut (
      .clk(clk), .reset(reset), .btn1(btn1), .btn2(btn2), .hit(hit), .miss(miss),
      .gra_still(gra_still), .game_state(game_state), .score_d1(score_d1),
      .score_d0(score_d0), .balls_left(balls_left)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] due;
      logic [12:0] outs;
   } exp_t;

   exp_t  exp_q[$];
   string name_q[$];
   int    cyc = 0;
   int    checks = 0;
   int    errors = 0;

   function automatic logic [12:0] pack_outs(logic [1:0] st, logic still, int score, logic [1:0] balls);
      logic [3:0] d1, d0;
      d1 = 4'(score / 10);
      d0 = 4'(score % 10);
      return {st, still, d1, d0, balls};
   endfunction

   task automatic cmp(string name, logic [12:0] got, logic [12:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s: got state=%b still=%b score=%h balls=%0d, want state=%b still=%b score=%h balls=%0d",
                  name, got[12:11], got[10], got[9:2], got[1:0], want[12:11], want[10], want[9:2], want[1:0]);
      end else begin
         $display("ok   %s: state=%b still=%b score=%h balls=%0d", name, got[12:11], got[10], got[9:2], got[1:0]);
      end
   endtask

   // Called at a falling edge with inputs already set: expect these outputs after the next rising edge.
   task automatic step(string name, logic [1:0] st, logic still, int score, logic [1:0] balls);
      exp_t e;
      e.due  = 32'(cyc + 1);
      e.outs = pack_outs(st, still, score, balls);
      exp_q.push_back(e);
      name_q.push_back(name);
      @(negedge clk);
   endtask

   initial begin : monitor
      exp_t  e;
      string n;
      forever begin
         @(posedge clk);
         cyc++;
         #2;
         while (exp_q.size() > 0 && exp_q[0].due <= 32'(cyc)) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            cmp(n, {game_state, gra_still, score_d1, score_d0, balls_left}, e.outs);
         end
      end
   end

   initial begin : stimulus
      reset = 1'b0; btn1 = 2'b00; btn2 = 2'b00; hit = 1'b0; miss = 1'b0;
      repeat (2) @(negedge clk);
      cmp("reset_hold", {game_state, gra_still, score_d1, score_d0, balls_left}, pack_outs(ST_NG, 1'b1, 0, 2'd3));
      reset = 1'b1;
      for (int i = 0; i < 10; i++) step("idle", ST_NG, 1'b1, 0, 2'd3);

      // held button gives exactly one start
      btn1 = 2'b01;
      for (int i = 0; i < 20; i++) step(i == 0 ? "start" : "btn_held", ST_PLAY, 1'b0, 0, 2'd2);
      btn1 = 2'b00;
      step("btn_release", ST_PLAY, 1'b0, 0, 2'd2);

      for (int i = 1; i <= 5; i++) begin
         hit = 1'b1; step("hit_pulse", ST_PLAY, 1'b0, i, 2'd2);
         hit = 1'b0; step("hit_gap", ST_PLAY, 1'b0, i, 2'd2);
      end

      // asynchronous reset mid-play
      reset = 1'b0;
      #1;
      cmp("async_reset", {game_state, gra_still, score_d1, score_d0, balls_left}, pack_outs(ST_NG, 1'b1, 0, 2'd3));
      @(negedge clk);
      reset = 1'b1;
      step("after_reset", ST_NG, 1'b1, 0, 2'd3);

      btn2 = 2'b10; step("restart", ST_PLAY, 1'b0, 0, 2'd2);
      btn2 = 2'b00; step("restart_rel", ST_PLAY, 1'b0, 0, 2'd2);

      // miss with balls left -> relaunch pause
      miss = 1'b1; step("miss_to_newball", ST_NB, 1'b1, 0, 2'd1);
      hit = 1'b1; miss = 1'b1; step("pulse_after_exit", ST_NB, 1'b1, 0, 2'd1);
      hit = 1'b0; miss = 1'b0;
      for (int k = 2; k <= 4; k++) step("pause", ST_NB, 1'b1, 0, 2'd1);
      btn2 = 2'b01; step("early_press", ST_NB, 1'b1, 0, 2'd1);
      btn2 = 2'b00;
      for (int k = 6; k <= 14; k++) step("pause", ST_NB, 1'b1, 0, 2'd1);
      btn2 = 2'b01; step("press_timer_1", ST_NB, 1'b1, 0, 2'd1);
      btn2 = 2'b00; step("pause", ST_NB, 1'b1, 0, 2'd1);
      btn2 = 2'b01; step("late_press", ST_PLAY, 1'b0, 0, 2'd1);
      btn2 = 2'b00; step("play_again", ST_PLAY, 1'b0, 0, 2'd1);

      // use the last spare ball
      miss = 1'b1; step("miss_last_spare", ST_NB, 1'b1, 0, 2'd0);
      miss = 1'b0;
      for (int k = 1; k <= 16; k++) step("pause", ST_NB, 1'b1, 0, 2'd0);
      btn1 = 2'b10; step("relaunch", ST_PLAY, 1'b0, 0, 2'd0);
      btn1 = 2'b00;

      hit = 1'b1;
      for (int i = 1; i <= 7; i++) step("hit_run", ST_PLAY, 1'b0, i, 2'd0);
      miss = 1'b1; step("hit_miss_same", ST_OVER, 1'b1, 8, 2'd0);
      hit = 1'b0; miss = 1'b0;

      // game-over hold; buttons ignored
      for (int k = 1; k <= 15; k++) begin
         if (k == 3) btn1 = 2'b11;
         if (k == 4) btn2 = 2'b01;
         if (k == 6) begin btn1 = 2'b00; btn2 = 2'b00; end
         step("over_hold", ST_OVER, 1'b1, 8, 2'd0);
      end
      step("over_to_newgame", ST_NG, 1'b1, 0, 2'd3);
      step("newgame_idle", ST_NG, 1'b1, 0, 2'd3);

      // score carry and saturation
      btn1 = 2'b01; step("start2", ST_PLAY, 1'b0, 0, 2'd2);
      btn1 = 2'b00; hit = 1'b1;
      for (int i = 1; i <= 101; i++) step(i == 12 ? "score_12" : "hit_run", ST_PLAY, 1'b0, (i > 99) ? 99 : i, 2'd2);
      hit = 1'b0; step("saturated", ST_PLAY, 1'b0, 99, 2'd2);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pong_game_ctrl.md
Name: pong_game_ctrl

Overview:
Game-flow controller for pong, sitting directly beside pong_graph in top.
- Consumes pong_graph's single-cycle hit and miss pulses and the debounced player buttons.
- Produces gra_still, which freezes paddles and ball, plus the score, balls remaining and game state.
- Text overlay and scoreboard logic read the score, balls and state outputs.
- Implements the newgame/play/over flow, a ball-relaunch pause and a game-over hold timer.

Parameters:
BALLS, 3, balls per game; 1..3, held in the 2-bit balls_left.
TIMER_CYCLES, 50_000_000, clk cycles of pause after a miss and hold in OVER (2 s at 25 MHz).
TIMER_W, 26, timer counter width; must satisfy 2^TIMER_W > TIMER_CYCLES.

Ports:
clk  in  1  system clock; single clock domain, all state on rising edge.
reset  in  1  asynchronous, active-low reset (asserted when 0).
btn1  in  2  player 1 buttons, debounced level signals.
btn2  in  2  player 2 buttons, debounced level signals.
hit  in  1  one-cycle pulse from pong_graph: paddle returned ball.
miss  in  1  one-cycle pulse from pong_graph: ball left the field.
gra_still  out  1  1 = graphics frozen; 0 = ball/paddles move.
game_state  out  2  00 newgame, 01 play, 10 over, 11 newball.
score_d1  out  4  BCD tens digit.
score_d0  out  4  BCD units digit.
balls_left  out  2  balls remaining after the one in play.

Behaviour:
- All outputs are registered. Moore decode from the state register, except the score, balls and timer registers.
- Reset (reset==0, async) forces:
  - state NEWGAME, gra_still=1, game_state=00;
  - score=00, balls_left=BALLS, timer=0, btn_any_q=0.
- Reset applies mid-operation in any state with the same values. No pulse is lost or replayed after release.
- Button start:
  - btn_any = |btn1 | |btn2; btn_any_q is its registered copy.
  - start = btn_any & ~btn_any_q (rising edge). Holding a button produces exactly one start.
- Timer: down-counter. Loaded with TIMER_CYCLES-1 on the transition into NEWBALL or OVER, then decrements each cycle. timer_up = (timer==0), and the counter holds at 0.
- NEWGAME (gra_still=1):
  - On start: go to PLAY, balls_left <= BALLS-1, score <= 00.
  - hit and miss are ignored.
- PLAY (gra_still=0):
  - hit increments the BCD score. d0 wraps 9->0 with a carry into d1; the score saturates at 99 (a hit at 99 leaves 99).
  - On miss with balls_left==0: go to OVER and load the timer.
  - On miss with balls_left>0: go to NEWBALL, balls_left-1, load the timer.
  - Simultaneous hit and miss in one cycle: both apply (score increments and the miss transition is taken).
- NEWBALL (gra_still=1):
  - hit and miss are ignored.
  - start while timer_up==0 is ignored.
  - start with timer_up==1: go to PLAY.
- OVER (gra_still=1):
  - Score held for display; buttons ignored.
  - When timer_up==1: go to NEWGAME; score <= 00, balls_left <= BALLS.
- Latency: an event (start, hit or miss) sampled at edge n shows on game_state, gra_still and score after edge n (visible in cycle n+1).
- hit or miss arriving the cycle after a transition out of PLAY is ignored.
- The state encoding equals game_state. Illegal or unused encodings are not reachable.

Test Plan:
Use TIMER_CYCLES=16 and BALLS=3 for all scenarios.
- Reset then idle 10 cycles -> game_state=00, gra_still=1, score=00, balls_left=3. Assert reset=0 mid-PLAY with score 05 -> outputs return to these values immediately (async).
- btn1=01 held high 20 cycles -> exactly one transition, to PLAY, on the cycle after the edge; balls_left=2, gra_still=0, no re-trigger while held.
- In PLAY, 12 hit pulses -> score_d1=1, score_d0=2. From 98, 3 hits -> 99 and stays 99.
- miss in PLAY (balls_left=2) -> NEWBALL, balls_left=1, gra_still=1.
  - btn2 press 5 cycles later is ignored.
  - Press after 16+ cycles -> PLAY.
- Same cycle hit+miss with score 07, balls_left=0 -> score 08 and state OVER. After 16 cycles -> NEWGAME, score 00, balls_left 3; buttons pressed during OVER have no effect.
